// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline constants for the decode-stage bypass logic.
//               Defines the stage index of each pipeline latch and the bit
//               layout helper for the flattened bypass_sel vector.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Stage indices of the tracked pipeline latches; 0 is the youngest.
  localparam int unsigned STG_DX = 0;
  localparam int unsigned STG_XM = 1;
  localparam int unsigned STG_MW = 2;

  // Bit position of (port, stage) inside the flattened bypass_sel vector.
  function automatic int unsigned sel_idx(input int unsigned port,
                                          input int unsigned stage,
                                          input int unsigned num_stages);
    return port * num_stages + stage;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bypass_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : bypass_scoreboard_if
// Description : Decode-side bus of the bypass scoreboard. Carries the F/D
//               instruction description, pipeline hold/squash controls and
//               the bypass select / stall results.
//   master : drives issue_*, src_*, freeze, flush; observes results
//   slave  : the scoreboard; observes inputs, drives bypass_sel, stall,
//            stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface bypass_scoreboard_if #(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 16
);
  logic                             issue_valid;
  logic                             issue_wr_en;
  logic                             issue_is_load;
  logic [REG_AW-1:0]                issue_rd;
  logic [NUM_RD_PORTS*REG_AW-1:0]   src_addr;
  logic [NUM_RD_PORTS-1:0]          src_used;
  logic                             freeze;
  logic                             flush;
  logic [NUM_RD_PORTS*NUM_STAGES-1:0] bypass_sel;
  logic                             stall;
  logic [CNT_W-1:0]                 stall_cnt;

  modport master (
    output issue_valid, issue_wr_en, issue_is_load, issue_rd,
           src_addr, src_used, freeze, flush,
    input  bypass_sel, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wr_en, issue_is_load, issue_rd,
           src_addr, src_used, freeze, flush,
    output bypass_sel, stall, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bypass_port_sel.sv
`default_nettype none
// ============================================================================
// Module      : bypass_port_sel
// Description : Bypass select for one source operand. Compares the operand
//               against every shadow entry and keeps only the youngest
//               match. If that match is a load whose data is not yet
//               available, the select is suppressed and haz is raised.
//   src_addr/src_used/issue_valid : operand being decoded
//   v/rd/ld                       : shadow entries, index 0 youngest
//   sel                           : one-hot stage select or 0
//   haz                           : load-use hazard on this operand
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_port_sel
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int REG_AW         = 5,
  parameter int LOAD_RDY_STAGE = 2
) (
  input  logic [REG_AW-1:0]                  src_addr,
  input  logic                               src_used,
  input  logic                               issue_valid,
  input  logic [NUM_STAGES-1:0]              v,
  input  logic [NUM_STAGES-1:0][REG_AW-1:0]  rd,
  input  logic [NUM_STAGES-1:0]              ld,
  output logic [NUM_STAGES-1:0]              sel,
  output logic                               haz
);

  logic [NUM_STAGES-1:0] match;
  logic [NUM_STAGES-1:0] sel_raw;
  logic                  found;

  always_comb begin
    match   = '0;
    sel_raw = '0;
    haz     = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      match[i] = src_used & v[i] & (rd[i] == src_addr) &
                 (src_addr != '0) & issue_valid;
    end
    // Scan from youngest; the first hit masks all older ones.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (match[i] && !found) begin
        found      = 1'b1;
        sel_raw[i] = 1'b1;
        haz        = ld[i] & (i < LOAD_RDY_STAGE);
      end
    end
    sel = haz ? '0 : sel_raw;
  end

endmodule
`default_nettype wire

// File: rtl/bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : bypass_scoreboard
// Description : Decode-stage bypass scoreboard. Holds a shadow of the
//               destination register of each tracked pipeline latch, drives
//               one-hot bypass selects per source operand (youngest match
//               wins), detects load-use hazards and counts stall cycles.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of bypass_scoreboard_if (F/D instruction in,
//           bypass_sel / stall / stall_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int NUM_RD_PORTS   = 2,
  parameter int REG_AW         = 5,
  parameter int LOAD_RDY_STAGE = 2,
  parameter int CNT_W          = 16
) (
  input  logic                clock,
  input  logic                reset,
  bypass_scoreboard_if.slave  bus
);

  // Shadow of in-flight destinations. v is only ever set for real
  // register writes (wr_en and rd != 0), so r0 and non-writers never match.
  logic [NUM_STAGES-1:0]             v_q;
  logic [NUM_STAGES-1:0][REG_AW-1:0] rd_q;
  logic [NUM_STAGES-1:0]             ld_q;
  logic [CNT_W-1:0]                  stall_cnt_q;

  logic [NUM_RD_PORTS-1:0][NUM_STAGES-1:0] port_sel;
  logic [NUM_RD_PORTS-1:0]                 port_haz;
  logic                                    stall;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    bypass_port_sel #(
      .NUM_STAGES     (NUM_STAGES),
      .REG_AW         (REG_AW),
      .LOAD_RDY_STAGE (LOAD_RDY_STAGE)
    ) u_port_sel (
      .src_addr    (bus.src_addr[p*REG_AW +: REG_AW]),
      .src_used    (bus.src_used[p]),
      .issue_valid (bus.issue_valid),
      .v           (v_q),
      .rd          (rd_q),
      .ld          (ld_q),
      .sel         (port_sel[p]),
      .haz         (port_haz[p])
    );
  end

  // A squashed F/D instruction cannot cause a hazard.
  assign stall = (|port_haz) & ~bus.flush;

  always_comb begin
    bus.bypass_sel = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        bus.bypass_sel[sel_idx(p, i, NUM_STAGES)] = port_sel[p][i];
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

  // Shadow shift register. Freeze holds everything; otherwise every entry
  // ages by one stage and the oldest falls off. Flush or stall inject a
  // bubble at stage 0 instead of the F/D instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      rd_q <= '0;
      ld_q <= '0;
    end else if (!bus.freeze) begin
      for (int i = 1; i < NUM_STAGES; i++) begin
        v_q[i]  <= v_q[i-1];
        rd_q[i] <= rd_q[i-1];
        ld_q[i] <= ld_q[i-1];
      end
      if (bus.flush || stall) begin
        v_q[STG_DX]  <= 1'b0;
        rd_q[STG_DX] <= '0;
        ld_q[STG_DX] <= 1'b0;
      end else begin
        v_q[STG_DX]  <= bus.issue_valid & bus.issue_wr_en & (bus.issue_rd != '0);
        rd_q[STG_DX] <= bus.issue_rd;
        ld_q[STG_DX] <= bus.issue_is_load & bus.issue_valid;
      end
    end
  end

  // Saturating stall-cycle counter; frozen cycles are not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && !bus.freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_bypass_scoreboard
// Description : Directed self-checking bench for bypass_scoreboard. Drives a
//               default 3-stage/2-port instance and a 4-stage/3-port
//               instance with a 4-bit stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_scoreboard;
  import pipeline_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  bypass_scoreboard_if #(.NUM_STAGES(3), .NUM_RD_PORTS(2), .REG_AW(5), .CNT_W(16)) bus1 ();
  bypass_scoreboard_if #(.NUM_STAGES(4), .NUM_RD_PORTS(3), .REG_AW(5), .CNT_W(4))  bus2 ();

  bypass_scoreboard #(.NUM_STAGES(3), .NUM_RD_PORTS(2), .REG_AW(5),
                      .LOAD_RDY_STAGE(2), .CNT_W(16)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1)
  );

  bypass_scoreboard #(.NUM_STAGES(4), .NUM_RD_PORTS(3), .REG_AW(5),
                      .LOAD_RDY_STAGE(2), .CNT_W(4)) dut2 (
    .clock (clock), .reset (reset), .bus (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive1(input logic valid, input logic wr, input logic ld,
                        input logic [4:0] rd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] used,
                        input logic frz, input logic fl);
    bus1.issue_valid   = valid;
    bus1.issue_wr_en   = wr;
    bus1.issue_is_load = ld;
    bus1.issue_rd      = rd;
    bus1.src_addr      = {s1, s0};
    bus1.src_used      = used;
    bus1.freeze        = frz;
    bus1.flush         = fl;
  endtask

  task automatic drive2(input logic valid, input logic wr, input logic ld,
                        input logic [4:0] rd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] used);
    bus2.issue_valid   = valid;
    bus2.issue_wr_en   = wr;
    bus2.issue_is_load = ld;
    bus2.issue_rd      = rd;
    bus2.src_addr      = {s2, s1, s0};
    bus2.src_used      = used;
    bus2.freeze        = 1'b0;
    bus2.flush         = 1'b0;
  endtask

  task automatic idle1(input int n);
    drive1(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with arbitrary inputs ----
    drive1(1, 1, 1, 5'd7, 5'd5, 5'd7, 2'b11, 0, 0);
    drive2(1, 1, 1, 5'd7, 5'd7, 5'd7, 5'd7, 3'b111);
    repeat (2) tick();
    check("rst_sel",   32'(bus1.bypass_sel), 32'h0);
    check("rst_stall", 32'(bus1.stall),      32'h0);
    check("rst_cnt",   32'(bus1.stall_cnt),  32'h0);
    idle1(0);
    drive2(0, 0, 0, 0, 0, 0, 0, 3'b000);
    reset = 1'b0;
    tick();

    // ---- simple forwarding: add r5 then consumer of r5 ----
    drive1(1, 1, 0, 5'd5, 0, 0, 2'b00, 0, 0);
    tick();
    drive1(1, 0, 0, 0, 5'd5, 0, 2'b01, 0, 0);
    #1;
    check("fwd_dx", 32'(bus1.bypass_sel), 32'(1) << STG_DX);
    check("fwd_dx_nostall", 32'(bus1.stall), 32'h0);
    tick();
    check("fwd_xm", 32'(bus1.bypass_sel), 32'(1) << STG_XM);
    tick();
    check("fwd_mw", 32'(bus1.bypass_sel), 32'(1) << STG_MW);
    tick();
    check("fwd_gone", 32'(bus1.bypass_sel), 32'h0);
    idle1(3);

    // ---- load-use: lw r7 then consumer of r7 ----
    drive1(1, 1, 1, 5'd7, 0, 0, 2'b00, 0, 0);
    tick();
    drive1(1, 0, 0, 0, 5'd7, 0, 2'b01, 0, 0);
    #1;
    check("lu_stall0", 32'(bus1.stall), 32'h1);
    check("lu_sel_masked", 32'(bus1.bypass_sel), 32'h0);
    tick();
    check("lu_stall1", 32'(bus1.stall), 32'h1);
    tick();
    check("lu_release", 32'(bus1.stall), 32'h0);
    check("lu_fwd_mw", 32'(bus1.bypass_sel), 32'h4);
    check("lu_cnt", 32'(bus1.stall_cnt), 32'd2);
    idle1(3);

    // ---- WAW / both ports / r0 / non-writers ----
    drive1(1, 1, 0, 5'd3, 0, 0, 2'b00, 0, 0); tick();
    drive1(1, 1, 0, 5'd1, 0, 0, 2'b00, 0, 0); tick();
    drive1(1, 1, 0, 5'd3, 0, 0, 2'b00, 0, 0); tick();
    // shadow: s0=r3, s1=r1, s2=r3
    drive1(1, 0, 0, 0, 5'd3, 5'd3, 2'b11, 0, 0); #1;
    check("waw_both", 32'(bus1.bypass_sel), 32'b001_001);
    drive1(1, 0, 0, 0, 5'd3, 5'd1, 2'b11, 0, 0); #1;
    check("ports_indep", 32'(bus1.bypass_sel), 32'b010_001);
    drive1(1, 0, 0, 0, 5'd3, 5'd1, 2'b01, 0, 0); #1;
    check("src_unused", 32'(bus1.bypass_sel), 32'b000_001);
    drive1(0, 0, 0, 0, 5'd3, 5'd1, 2'b11, 0, 0); #1;
    check("no_valid", 32'(bus1.bypass_sel), 32'h0);
    drive1(1, 1, 0, 5'd0, 0, 0, 2'b00, 0, 0); tick();   // write to r0
    drive1(1, 0, 0, 5'd6, 0, 0, 2'b00, 0, 0); tick();   // non-writer naming r6
    // shadow: s0=r6(no write), s1=r0, s2=r3
    drive1(1, 0, 0, 0, 5'd6, 5'd0, 2'b11, 0, 0); #1;
    check("r0_nowr", 32'(bus1.bypass_sel), 32'h0);
    drive1(1, 0, 0, 0, 5'd6, 5'd3, 2'b11, 0, 0); #1;
    check("old_r3", 32'(bus1.bypass_sel), 32'b100_000);
    idle1(3);

    // ---- freeze with pending r9 at stage 1 ----
    drive1(1, 1, 0, 5'd9, 0, 0, 2'b00, 0, 0); tick();
    idle1(1);
    drive1(1, 0, 0, 0, 5'd9, 0, 2'b01, 1, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("frz_sel", 32'(bus1.bypass_sel), 32'b000_010);
      tick();
    end
    check("frz_cnt", 32'(bus1.stall_cnt), 32'd2);
    idle1(3);

    // ---- freeze during a load-use stall, then flush ----
    drive1(1, 1, 1, 5'd8, 0, 0, 2'b00, 0, 0); tick();
    drive1(1, 0, 0, 0, 5'd8, 0, 2'b01, 1, 0); #1;
    check("frz_stall", 32'(bus1.stall), 32'h1);
    repeat (3) tick();
    check("frz_stall_cnt", 32'(bus1.stall_cnt), 32'd2);
    drive1(1, 1, 0, 5'd10, 5'd8, 0, 2'b01, 0, 1); #1;
    check("flush_stall", 32'(bus1.stall), 32'h0);
    check("flush_sel", 32'(bus1.bypass_sel), 32'h0);
    tick();
    drive1(1, 0, 0, 0, 5'd8, 5'd10, 2'b11, 0, 0); #1;
    check("flush_bubble_stall", 32'(bus1.stall), 32'h1);
    check("flush_bubble_sel", 32'(bus1.bypass_sel), 32'h0);
    check("flush_cnt", 32'(bus1.stall_cnt), 32'd2);
    tick();
    check("post_flush_stall", 32'(bus1.stall), 32'h0);
    check("post_flush_sel", 32'(bus1.bypass_sel), 32'b000_100);
    check("post_flush_cnt", 32'(bus1.stall_cnt), 32'd3);

    // ---- asynchronous reset mid-operation ----
    drive1(1, 1, 0, 5'd12, 0, 0, 2'b00, 0, 0); tick();
    drive1(1, 0, 0, 0, 5'd12, 0, 2'b01, 0, 0); #1;
    check("pre_rst_sel", 32'(bus1.bypass_sel), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_sel", 32'(bus1.bypass_sel), 32'h0);
    check("rst_async_cnt", 32'(bus1.stall_cnt), 32'h0);
    #2 reset = 1'b0;
    #1;
    check("post_rst_sel", 32'(bus1.bypass_sel), 32'h0);
    tick();
    check("post_rst_sel2", 32'(bus1.bypass_sel), 32'h0);
    idle1(1);

    // ---- 4-stage / 3-port instance: oldest stage and port 2 ----
    drive2(1, 1, 0, 5'd11, 0, 0, 0, 3'b000); tick();
    drive2(0, 0, 0, 0, 0, 0, 0, 3'b000); repeat (3) tick();
    drive2(1, 0, 0, 0, 5'd11, 5'd11, 5'd11, 3'b101); #1;
    check("p3_stage3", 32'(bus2.bypass_sel), 32'h808);
    tick();
    check("p3_discard", 32'(bus2.bypass_sel), 32'h0);
    drive2(0, 0, 0, 0, 0, 0, 0, 3'b000); repeat (4) tick();

    // ---- repeated load-use: 2 stall cycles every 3, 4-bit counter ----
    drive2(1, 1, 1, 5'd7, 5'd7, 0, 0, 3'b001);
    repeat (22) tick();
    check("sat_cnt14", 32'(bus2.stall_cnt), 32'd14);
    repeat (8) tick();
    check("sat15", 32'(bus2.stall_cnt), 32'd15);
    repeat (10) tick();
    check("sat_hold", 32'(bus2.stall_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
